// File: rtl/red_tree_pipe.sv
// red_tree_pipe: N-input AND/OR/XOR/NAND reduction built as a balanced tree of 2-input nodes.
// PIPE=1 registers every tree level (latency LV); PIPE=0 registers only the final result.
module red_tree_pipe #(
  parameter int N    = 7,
  parameter int PIPE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         vi,
  input  logic [1:0]   mode,
  input  logic [N-1:0] x,
  output logic         vo,
  output logic         y
);
  localparam int LV  = (N <= 2) ? 1 : $clog2(N);
  localparam int LAT = (PIPE != 0) ? LV : 1;
  localparam int W   = 1 << LV;

  // 2-input tree node; NAND shares the AND node, inversion happens once at the end.
  function automatic logic node(input logic a, input logic b, input logic [1:0] m);
    case (m)
      2'd1:    node = a | b;
      2'd2:    node = a ^ b;
      default: node = a & b;
    endcase
  endfunction

  logic         ident;
  logic [W-1:0] lvl0;

  assign ident = (mode == 2'd0) || (mode == 2'd3);

  always_comb begin
    lvl0        = {W{ident}};
    lvl0[N-1:0] = x;
  end

  if (PIPE != 0) begin : g_pipe
    for (genvar gi = 1; gi <= LAT; gi++) begin : g_stg
      localparam int IW = W >> (gi - 1);
      localparam int OW = W >> gi;

      logic [IW-1:0] prev;
      logic          prev_v;
      logic [1:0]    prev_m;
      logic [OW-1:0] d_d;
      logic [OW-1:0] d_q;
      logic          v_q;

      if (gi == 1) begin : g_src
        assign prev   = lvl0;
        assign prev_v = vi;
        assign prev_m = mode;
      end else begin : g_src
        assign prev   = g_stg[gi-1].d_q;
        assign prev_v = g_stg[gi-1].v_q;
        assign prev_m = g_stg[gi-1].g_m.m_q;
      end

      always_comb begin
        d_d = '0;
        for (int j = 0; j < OW; j++) begin
          d_d[j] = node(prev[2*j], prev[2*j+1], prev_m);
        end
        if (gi == LAT && prev_m == 2'd3) begin
          d_d = ~d_d;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          d_q <= '0;
          v_q <= 1'b0;
        end else if (en) begin
          d_q <= d_d;
          v_q <= prev_v;
        end
      end

      // The last stage has no consumer of its mode, so only inner stages carry it on.
      if (gi < LAT) begin : g_m
        logic [1:0] m_q;
        always_ff @(posedge clk) begin
          if (rst) begin
            m_q <= '0;
          end else if (en) begin
            m_q <= prev_m;
          end
        end
      end
    end

    assign y  = g_stg[LAT].d_q[0];
    assign vo = g_stg[LAT].v_q;
  end else begin : g_comb
    logic [W-1:0]   t;
    logic           y_d;
    logic [LAT-1:0] y_q;
    logic [LAT-1:0] v_q;

    // In-place halving: node j of a level only overwrites slots already consumed.
    always_comb begin
      t = lvl0;
      for (int k = LV - 1; k >= 0; k--) begin
        for (int j = 0; j < (1 << k); j++) begin
          t[j] = node(t[2*j], t[2*j+1], mode);
        end
      end
      y_d = t[0] ^ (mode == 2'd3);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        y_q <= '0;
        v_q <= '0;
      end else if (en) begin
        y_q <= y_d;
        v_q <= vi;
      end
    end

    assign y  = y_q[LAT-1];
    assign vo = v_q[LAT-1];
  end

endmodule

// File: tb/tb_red_tree_pipe.sv
// Directed checks of red_tree_pipe (N=7, PIPE=1) plus a random sweep over N=1/8/13, PIPE=0/1.
module tb_red_tree_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       vi;
  logic [1:0] mode;
  logic [6:0] x;
  logic       vo;
  logic       y;

  logic        sw_vi;
  logic [1:0]  sw_mode;
  logic [12:0] sw_x;
  logic [5:0]  sw_vo;
  logic [5:0]  sw_y;

  int n_cmp = 0;
  int n_err = 0;

  // sweep configs: 0 N1P0, 1 N1P1, 2 N8P0, 3 N8P1, 4 N13P0, 5 N13P1
  int cfg_n   [6] = '{1, 1, 8, 8, 13, 13};
  int cfg_lat [6] = '{1, 1, 1, 3, 1, 4};

  localparam int NS = 1000;
  logic        hist_v [NS];
  logic [1:0]  hist_m [NS];
  logic [12:0] hist_x [NS];

  always #5 clk = ~clk;

  red_tree_pipe #(.N(7), .PIPE(1)) dut (
    .clk(clk), .rst(rst), .en(en), .vi(vi), .mode(mode), .x(x), .vo(vo), .y(y)
  );

  red_tree_pipe #(.N(1), .PIPE(0)) s0 (
    .clk(clk), .rst(rst), .en(en), .vi(sw_vi), .mode(sw_mode), .x(sw_x[0:0]), .vo(sw_vo[0]), .y(sw_y[0])
  );
  red_tree_pipe #(.N(1), .PIPE(1)) s1 (
    .clk(clk), .rst(rst), .en(en), .vi(sw_vi), .mode(sw_mode), .x(sw_x[0:0]), .vo(sw_vo[1]), .y(sw_y[1])
  );
  red_tree_pipe #(.N(8), .PIPE(0)) s2 (
    .clk(clk), .rst(rst), .en(en), .vi(sw_vi), .mode(sw_mode), .x(sw_x[7:0]), .vo(sw_vo[2]), .y(sw_y[2])
  );
  red_tree_pipe #(.N(8), .PIPE(1)) s3 (
    .clk(clk), .rst(rst), .en(en), .vi(sw_vi), .mode(sw_mode), .x(sw_x[7:0]), .vo(sw_vo[3]), .y(sw_y[3])
  );
  red_tree_pipe #(.N(13), .PIPE(0)) s4 (
    .clk(clk), .rst(rst), .en(en), .vi(sw_vi), .mode(sw_mode), .x(sw_x), .vo(sw_vo[4]), .y(sw_y[4])
  );
  red_tree_pipe #(.N(13), .PIPE(1)) s5 (
    .clk(clk), .rst(rst), .en(en), .vi(sw_vi), .mode(sw_mode), .x(sw_x), .vo(sw_vo[5]), .y(sw_y[5])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_red(input logic [12:0] v, input int n, input logic [1:0] m);
    logic a, o, xr;
    a = 1'b1;
    o = 1'b0;
    xr = 1'b0;
    for (int b = 0; b < n; b++) begin
      a  = a & v[b];
      o  = o | v[b];
      xr = xr ^ v[b];
    end
    case (m)
      2'd0:    return a;
      2'd1:    return o;
      2'd2:    return xr;
      default: return ~a;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; vi = 1'b1; x = 7'h7F; mode = 2'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (vo !== 1'b0) begin n_err++; $display("FAIL reset_vo cyc%0d: got %b want 0", i, vo); end
      n_cmp++;
      if (y !== 1'b0) begin n_err++; $display("FAIL reset_y cyc%0d: got %b want 0", i, y); end
    end
    rst = 1'b0; vi = 1'b0; x = 7'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (vo !== 1'b0) begin n_err++; $display("FAIL post_reset_vo cyc%0d: got %b want 0", i, vo); end
      n_cmp++;
      if (y !== 1'b0) begin n_err++; $display("FAIL post_reset_y cyc%0d: got %b want 0", i, y); end
    end
  endtask

  task automatic test_latency();
    logic [6:0] xs [3] = '{7'h7F, 7'h7E, 7'h7F};
    logic [1:0] ms [3] = '{2'd0, 2'd0, 2'd3};
    bit         ev [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit         ey [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin vi = 1'b1; x = xs[i]; mode = ms[i]; end
      else begin vi = 1'b0; x = 7'h00; mode = 2'd0; end
      step();
      n_cmp++;
      if (vo !== ev[i]) begin n_err++; $display("FAIL latency_vo cyc%0d: got %b want %b", i, vo, ev[i]); end
      if (ev[i]) begin
        n_cmp++;
        if (y !== ey[i]) begin n_err++; $display("FAIL latency_y cyc%0d: got %b want %b", i, y, ey[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] xs [4] = '{7'h01, 7'h01, 7'h01, 7'h03};
    logic [1:0] ms [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    bit         ev [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit         ey [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin vi = 1'b1; x = xs[i]; mode = ms[i]; end
      else begin vi = 1'b0; x = 7'h00; mode = 2'd0; end
      step();
      n_cmp++;
      if (vo !== ev[i]) begin n_err++; $display("FAIL b2b_vo cyc%0d: got %b want %b", i, vo, ev[i]); end
      if (ev[i]) begin
        n_cmp++;
        if (y !== ey[i]) begin n_err++; $display("FAIL b2b_y cyc%0d: got %b want %b", i, y, ey[i]); end
      end
    end
  endtask

  task automatic test_freeze();
    // frozen mid-flight: sample sits in stage 2 while the bubble in stage 3 stays presented
    vi = 1'b1; x = 7'h7F; mode = 2'd0; en = 1'b1;
    step();
    vi = 1'b0; x = 7'h00;
    step();
    en = 1'b0; vi = 1'b1; x = 7'h55; mode = 2'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (vo !== 1'b0) begin n_err++; $display("FAIL freeze_vo cyc%0d: got %b want 0", i, vo); end
      n_cmp++;
      if (y !== 1'b0) begin n_err++; $display("FAIL freeze_y cyc%0d: got %b want 0", i, y); end
    end
    en = 1'b1; vi = 1'b0; x = 7'h00; mode = 2'd0;
    step();
    n_cmp++;
    if (vo !== 1'b1 || y !== 1'b1) begin
      n_err++; $display("FAIL freeze_release: got vo=%b y=%b want vo=1 y=1", vo, y);
    end
    step();
    n_cmp++;
    if (vo !== 1'b0) begin n_err++; $display("FAIL freeze_after_vo: got %b want 0", vo); end

    // frozen while a result is presented: it must stay presented
    vi = 1'b1; x = 7'h7F; mode = 2'd0;
    step();
    vi = 1'b0; x = 7'h00;
    step();
    step();
    n_cmp++;
    if (vo !== 1'b1 || y !== 1'b1) begin
      n_err++; $display("FAIL hold_pre: got vo=%b y=%b want vo=1 y=1", vo, y);
    end
    en = 1'b0; vi = 1'b1; mode = 2'd2;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (vo !== 1'b1 || y !== 1'b1) begin
        n_err++; $display("FAIL hold_out cyc%0d: got vo=%b y=%b want vo=1 y=1", i, vo, y);
      end
    end
    en = 1'b1; vi = 1'b0; mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (vo !== 1'b0) begin n_err++; $display("FAIL hold_after_vo cyc%0d: got %b want 0", i, vo); end
    end
  endtask

  task automatic test_midflight_reset();
    vi = 1'b1; x = 7'h7F; mode = 2'd0; en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (vo !== 1'b1 || y !== 1'b1) begin
      n_err++; $display("FAIL mid_first: got vo=%b y=%b want vo=1 y=1", vo, y);
    end
    rst = 1'b1; vi = 1'b0;
    step();
    n_cmp++;
    if (vo !== 1'b0 || y !== 1'b0) begin
      n_err++; $display("FAIL mid_rst: got vo=%b y=%b want vo=0 y=0", vo, y);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (vo !== 1'b0) begin n_err++; $display("FAIL mid_after_vo cyc%0d: got %b want 0", i, vo); end
    end
  endtask

  task automatic test_sweep();
    en = 1'b1;
    for (int i = 0; i < NS; i++) begin
      sw_vi   = ($urandom_range(0, 3) != 0);
      sw_mode = 2'($urandom_range(0, 3));
      sw_x    = ($urandom_range(0, 3) == 0) ? 13'h1FFF : 13'($urandom);
      hist_v[i] = sw_vi;
      hist_m[i] = sw_mode;
      hist_x[i] = sw_x;
      step();
      for (int c = 0; c < 6; c++) begin
        int  j;
        bit  ev;
        bit  ey;
        j  = i - cfg_lat[c] + 1;
        ev = (j >= 0) ? hist_v[j] : 1'b0;
        ey = (j >= 0) ? ref_red(hist_x[j], cfg_n[c], hist_m[j]) : 1'b0;
        n_cmp++;
        if (sw_vo[c] !== ev) begin
          n_err++; $display("FAIL sweep_vo cfg%0d N=%0d i=%0d: got %b want %b", c, cfg_n[c], i, sw_vo[c], ev);
        end
        if (ev) begin
          n_cmp++;
          if (sw_y[c] !== ey) begin
            n_err++;
            $display("FAIL sweep_y cfg%0d N=%0d i=%0d mode=%0d x=%h: got %b want %b",
                     c, cfg_n[c], i, hist_m[j], hist_x[j], sw_y[c], ey);
          end
        end
      end
    end
    sw_vi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; vi = 1'b0; mode = 2'd0; x = 7'h00;
    sw_vi = 1'b0; sw_mode = 2'd0; sw_x = 13'h0000;
    test_reset();
    test_latency();
    test_back_to_back();
    test_freeze();
    test_midflight_reset();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
